lsq_mem_stage: RTL and testbench

- Memory-access stage directly downstream of the load/store queue.
- Accepts one issued 192-bit LSQ entry and performs the data-memory transaction for it: byte-lane alignment, byte enables, load extension, and a request/ack handshake.
- Broadcasts the completed result (ROB number, destination tag, load data) to the CDB/ROB.
- Drives DMISS back to the LSQ so that only one access is in flight at a time.

---
 rtl/lsq_mem_stage_pkg.sv | 35 +++
 rtl/lsq_mem_stage_if.sv | 20 ++
 rtl/lsq_mem_stage_align.sv | 44 ++++
 rtl/lsq_mem_stage.sv | 136 +++++++++++++
 tb/tb_lsq_mem_stage.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_mem_stage_pkg.sv
// Shared definitions for the LSQ memory-access stage: entry field map, size codes, FSM encoding.
package lsq_pkg;

   localparam int VALID_BIT    = 191;
   localparam int DEST_HI      = 185;
   localparam int DEST_LO      = 180;
   localparam int ROB_HI       = 159;
   localparam int ROB_LO       = 154;
   localparam int MEMREAD_BIT  = 135;
   localparam int MEMWRITE_BIT = 133;
   localparam int SIZE_HI      = 132;
   localparam int SIZE_LO      = 131;
   localparam int UNSIGNED_BIT = 130;
   localparam int ADDR_HI      = 95;
   localparam int ADDR_LO      = 64;
   localparam int SDATA_HI     = 31;
   localparam int SDATA_LO     = 0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_WB     = 2'd3;

   // The unused size code 2'b11 is treated as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      if (size == SZ_BYTE)      return 1'b0;
      else if (size == SZ_HALF) return lo[0];
      else                      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/lsq_mem_stage_if.sv
// Data-memory request/ack bus between the memory stage (master) and the data memory (slave).
interface lsq_mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsq_mem_stage_align.sv
// Byte-lane alignment: byte enables, replicated store data, misalign detect and load extension.
module mem_align
   import lsq_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o,
   output logic [31:0] ldata_o
);

   logic [31:0] lane;

   assign lane       = rdata_i >> {addr_lo_i, 3'b000};
   assign misalign_o = is_misaligned(size_i, addr_lo_i);

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = sdata_i;
      ldata_o = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{sdata_i[7:0]}};
            ldata_o = uns_i ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         end
         SZ_HALF: begin
            be_o    = 4'b0011 << addr_lo_i;
            wdata_o = {2{sdata_i[15:0]}};
            ldata_o = uns_i ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = sdata_i;
            ldata_o = rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsq_mem_stage.sv
// Memory-access stage behind the LSQ: one access in flight, result broadcast on the CDB.
//   state  | meaning
//   IDLE   | waiting for an issued entry
//   ACCESS | mem_req high, waiting for mem_ack
//   DRAIN  | flushed mid-access; finish the handshake, no broadcast
//   WB     | cdb_valid high, held while FREEZE
module lsq_mem_stage
   import lsq_pkg::*;
#(
   parameter int ENTRY_W = 192,
   parameter int ROB_W   = 6,
   parameter int TAG_W   = 6
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               FREEZE,
   input  logic               mispredict,
   input  logic               flush_fCOM,
   input  logic               do_issue,
   input  logic [ENTRY_W-1:0] lsq_entry,
   output logic               DMISS,
   lsq_mem_stage_if.master    mem,
   output logic               cdb_valid,
   output logic [ROB_W-1:0]   cdb_rob,
   output logic [TAG_W-1:0]   cdb_tag,
   output logic [31:0]        cdb_data,
   output logic               cdb_regwrite,
   output logic               cdb_exc
);

   logic [1:0]       state_q, state_d;
   logic [ROB_W-1:0] rob_q;
   logic [TAG_W-1:0] tag_q;
   logic             rd_q, we_q, uns_q, regwrite_q, exc_q;
   logic [1:0]       size_q;
   logic [31:0]      addr_q, wdata_q, data_q;
   logic [3:0]       be_q;

   logic        flush, idle, accept, mem_op;
   logic [1:0]  al_size, al_lo;
   logic        al_uns, al_misalign;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_ldata;
   logic        unused_entry_bits;

   assign flush  = mispredict | flush_fCOM;
   assign idle   = state_q == ST_IDLE;
   assign accept = idle && do_issue && lsq_entry[VALID_BIT] && !FREEZE && !flush;
   assign mem_op = lsq_entry[MEMREAD_BIT] | lsq_entry[MEMWRITE_BIT];

   // The aligner sees the incoming entry while idle and the captured access afterwards.
   assign al_size = idle ? lsq_entry[SIZE_HI:SIZE_LO]       : size_q;
   assign al_uns  = idle ? lsq_entry[UNSIGNED_BIT]          : uns_q;
   assign al_lo   = idle ? lsq_entry[ADDR_LO+1:ADDR_LO]     : addr_q[1:0];

   mem_align u_align (
      .size_i     (al_size),
      .uns_i      (al_uns),
      .addr_lo_i  (al_lo),
      .sdata_i    (lsq_entry[SDATA_HI:SDATA_LO]),
      .rdata_i    (mem.mem_rdata),
      .be_o       (al_be),
      .wdata_o    (al_wdata),
      .misalign_o (al_misalign),
      .ldata_o    (al_ldata)
   );

   assign unused_entry_bits = ^{lsq_entry[190:186], lsq_entry[179:160], lsq_entry[153:136],
                                lsq_entry[134], lsq_entry[129:96], lsq_entry[63:32]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = (!mem_op || al_misalign) ? ST_WB : ST_ACCESS;
         ST_ACCESS: begin
            // An in-flight memory transaction is never abandoned; flush only suppresses the broadcast.
            if (mem.mem_ack)  state_d = flush ? ST_IDLE : ST_WB;
            else if (flush)   state_d = ST_DRAIN;
         end
         ST_DRAIN:  if (mem.mem_ack) state_d = ST_IDLE;
         ST_WB:     if (flush || !FREEZE) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         rob_q      <= '0;
         tag_q      <= '0;
         rd_q       <= 1'b0;
         we_q       <= 1'b0;
         uns_q      <= 1'b0;
         size_q     <= '0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         data_q     <= '0;
         regwrite_q <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rob_q      <= lsq_entry[ROB_HI:ROB_LO];
            tag_q      <= lsq_entry[DEST_HI:DEST_LO];
            rd_q       <= lsq_entry[MEMREAD_BIT];
            we_q       <= lsq_entry[MEMWRITE_BIT];
            uns_q      <= lsq_entry[UNSIGNED_BIT];
            size_q     <= lsq_entry[SIZE_HI:SIZE_LO];
            addr_q     <= lsq_entry[ADDR_HI:ADDR_LO];
            be_q       <= al_be;
            wdata_q    <= al_wdata;
            data_q     <= '0;
            regwrite_q <= lsq_entry[MEMREAD_BIT];
            exc_q      <= mem_op & al_misalign;
         end
         if (state_q == ST_ACCESS && mem.mem_ack)
            data_q <= rd_q ? al_ldata : 32'd0;
      end
   end

   assign DMISS         = !idle;
   assign mem.mem_req   = (state_q == ST_ACCESS) || (state_q == ST_DRAIN);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = {addr_q[31:2], 2'b00};
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;

   assign cdb_valid    = (state_q == ST_WB) && !flush;
   assign cdb_rob      = rob_q;
   assign cdb_tag      = tag_q;
   assign cdb_data     = data_q;
   assign cdb_regwrite = cdb_valid & regwrite_q;
   assign cdb_exc      = cdb_valid & exc_q;

endmodule

// File: tb/tb_lsq_mem_stage.sv
// Scoreboard bench for lsq_mem_stage: directed entries, a memory responder and a CDB monitor.
module tb_lsq_mem_stage;
   import lsq_pkg::*;

   logic         CLK = 1'b0;
   logic         RESET, FREEZE, mispredict, flush_fCOM, do_issue;
   logic [191:0] lsq_entry;
   logic         DMISS, cdb_valid, cdb_regwrite, cdb_exc;
   logic [5:0]   cdb_rob, cdb_tag;
   logic [31:0]  cdb_data;

   lsq_mem_stage_if mif ();

   lsq_mem_stage dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .FREEZE       (FREEZE),
      .mispredict   (mispredict),
      .flush_fCOM   (flush_fCOM),
      .do_issue     (do_issue),
      .lsq_entry    (lsq_entry),
      .DMISS        (DMISS),
      .mem          (mif),
      .cdb_valid    (cdb_valid),
      .cdb_rob      (cdb_rob),
      .cdb_tag      (cdb_tag),
      .cdb_data     (cdb_data),
      .cdb_regwrite (cdb_regwrite),
      .cdb_exc      (cdb_exc)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
   } mem_exp_t;

   typedef struct {
      logic [5:0]  rob;
      logic [5:0]  tag;
      logic [31:0] data;
      logic        regwrite;
      logic        exc;
      int          hold;
   } cdb_exp_t;

   mem_exp_t mq[$];
   cdb_exp_t cq[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [191:0] mk(input logic [5:0] tag, input logic [5:0] rob,
                                        input logic rd, input logic wr, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] addr,
                                        input logic [31:0] sdata);
      logic [191:0] e;
      e = '0;
      e[VALID_BIT]           = 1'b1;
      e[DEST_HI:DEST_LO]     = tag;
      e[ROB_HI:ROB_LO]       = rob;
      e[MEMREAD_BIT]         = rd;
      e[MEMWRITE_BIT]        = wr;
      e[SIZE_HI:SIZE_LO]     = sz;
      e[UNSIGNED_BIT]        = uns;
      e[ADDR_HI:ADDR_LO]     = addr;
      e[SDATA_HI:SDATA_LO]   = sdata;
      return e;
   endfunction

   function automatic mem_exp_t me(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                   input logic [31:0] wdata, input int delay,
                                   input logic [31:0] rdata);
      mem_exp_t m;
      m.addr = addr; m.we = we; m.be = be; m.wdata = wdata; m.delay = delay; m.rdata = rdata;
      return m;
   endfunction

   function automatic cdb_exp_t ce(input logic [5:0] rob, input logic [5:0] tag,
                                   input logic [31:0] data, input logic regwrite,
                                   input logic exc, input int hold);
      cdb_exp_t c;
      c.rob = rob; c.tag = tag; c.data = data; c.regwrite = regwrite; c.exc = exc; c.hold = hold;
      return c;
   endfunction

   // Memory responder: checks request fields every cycle and acks after the programmed delay.
   mem_exp_t cur;
   bit       busy = 0;
   int       cnt  = 0;
   initial begin
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = '0;
      forever begin
         @(negedge CLK);
         mif.mem_ack = 1'b0;
         if (RESET) begin
            busy = 0;
         end else if (mif.mem_req) begin
            if (!busy && mq.size() == 0) begin
               check("unexpected_mem_req", {31'd0, mif.mem_req}, 32'd0);
            end else begin
               if (!busy) begin
                  cur  = mq[0];
                  busy = 1;
                  cnt  = 0;
               end
               cnt++;
               check("mem_addr",  mif.mem_addr, cur.addr);
               check("mem_we",    {31'd0, mif.mem_we}, {31'd0, cur.we});
               check("mem_be",    {28'd0, mif.mem_be}, {28'd0, cur.be});
               check("mem_wdata", mif.mem_wdata, cur.wdata);
               if (cnt == cur.delay) begin
                  mif.mem_ack   = 1'b1;
                  mif.mem_rdata = cur.rdata;
                  void'(mq.pop_front());
                  busy = 0;
               end
            end
         end
      end
   end

   // CDB monitor: compares every broadcast cycle, pops when the broadcast can retire.
   int hold = 0;
   initial begin
      forever begin
         @(negedge CLK);
         if (!RESET && cdb_valid) begin
            if (cq.size() == 0) begin
               check("unexpected_cdb_valid", {31'd0, cdb_valid}, 32'd0);
            end else begin
               hold++;
               check("cdb_rob",      {26'd0, cdb_rob}, {26'd0, cq[0].rob});
               check("cdb_tag",      {26'd0, cdb_tag}, {26'd0, cq[0].tag});
               check("cdb_data",     cdb_data, cq[0].data);
               check("cdb_regwrite", {31'd0, cdb_regwrite}, {31'd0, cq[0].regwrite});
               check("cdb_exc",      {31'd0, cdb_exc}, {31'd0, cq[0].exc});
               if (!FREEZE) begin
                  check("cdb_hold_cycles", hold, cq[0].hold);
                  void'(cq.pop_front());
                  hold = 0;
               end
            end
         end
      end
   end

   task automatic issue(input logic [191:0] e);
      @(posedge CLK); #1;
      lsq_entry = e;
      do_issue  = 1'b1;
      @(posedge CLK); #1;
      do_issue  = 1'b0;
      lsq_entry = '0;
   endtask

   task automatic wait_dmiss(output int n);
      n = 0;
      while (DMISS && n < 60) begin
         n++;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   int n;
   initial begin
      RESET = 1'b1; FREEZE = 1'b0; mispredict = 1'b0; flush_fCOM = 1'b0;
      do_issue = 1'b0; lsq_entry = '0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;

      check("reset_dmiss",     {31'd0, DMISS}, 32'd0);
      check("reset_mem_req",   {31'd0, mif.mem_req}, 32'd0);
      check("reset_mem_addr",  mif.mem_addr, 32'd0);
      check("reset_mem_be",    {28'd0, mif.mem_be}, 32'd0);
      check("reset_mem_wdata", mif.mem_wdata, 32'd0);
      check("reset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
      check("reset_cdb_data",  cdb_data, 32'd0);
      check("reset_cdb_flags", {30'd0, cdb_regwrite, cdb_exc}, 32'd0);

      // Word load, ack on third access cycle.
      mq.push_back(me(32'h100, 1'b0, 4'b1111, 32'h0, 3, 32'hDEADBEEF));
      cq.push_back(ce(6'd5, 6'd12, 32'hDEADBEEF, 1'b1, 1'b0, 1));
      issue(mk(6'd12, 6'd5, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0));
      wait_dmiss(n);
      check("dmiss_cycles_word_load", n, 4);

      // Signed then unsigned byte load from lane 3.
      mq.push_back(me(32'h100, 1'b0, 4'b1000, 32'h0, 1, 32'h80123456));
      cq.push_back(ce(6'd7, 6'd3, 32'hFFFFFF80, 1'b1, 1'b0, 1));
      issue(mk(6'd3, 6'd7, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0));
      wait_dmiss(n);
      check("dmiss_cycles_sbyte", n, 2);

      mq.push_back(me(32'h100, 1'b0, 4'b1000, 32'h0, 1, 32'h80123456));
      cq.push_back(ce(6'd8, 6'd3, 32'h00000080, 1'b1, 1'b0, 1));
      issue(mk(6'd3, 6'd8, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0));
      wait_dmiss(n);
      check("dmiss_cycles_ubyte", n, 2);

      // Half store to upper lanes.
      mq.push_back(me(32'h200, 1'b1, 4'b1100, 32'hABCDABCD, 2, 32'h0));
      cq.push_back(ce(6'd9, 6'd4, 32'h0, 1'b0, 1'b0, 1));
      issue(mk(6'd4, 6'd9, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h202, 32'h0000ABCD));
      wait_dmiss(n);
      check("dmiss_cycles_half_store", n, 3);

      // Misaligned word load: exception, no memory request.
      cq.push_back(ce(6'd10, 6'd1, 32'h0, 1'b1, 1'b1, 1));
      issue(mk(6'd1, 6'd10, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0));
      wait_dmiss(n);
      check("dmiss_cycles_misaligned", n, 1);

      // Signed half load from lane 2.
      mq.push_back(me(32'h300, 1'b0, 4'b1100, 32'h0, 1, 32'h9ABC1234));
      cq.push_back(ce(6'd11, 6'd7, 32'hFFFF9ABC, 1'b1, 1'b0, 1));
      issue(mk(6'd7, 6'd11, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h302, 32'h0));
      wait_dmiss(n);
      check("dmiss_cycles_shalf", n, 2);

      // Entry that neither reads nor writes: straight to writeback.
      cq.push_back(ce(6'd12, 6'd2, 32'h0, 1'b0, 1'b0, 1));
      issue(mk(6'd2, 6'd12, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0));
      wait_dmiss(n);
      check("dmiss_cycles_noop", n, 1);

      // Mispredict during access: handshake completes, no broadcast.
      mq.push_back(me(32'h400, 1'b0, 4'b1111, 32'h0, 3, 32'h11111111));
      issue(mk(6'd6, 6'd13, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0));
      fork
         wait_dmiss(n);
         begin
            mispredict = 1'b1;
            @(posedge CLK); #1;
            mispredict = 1'b0;
         end
      join
      check("dmiss_cycles_mispredict", n, 3);
      repeat (3) @(posedge CLK);

      // FREEZE across the ack cycle holds the broadcast for three cycles.
      mq.push_back(me(32'h500, 1'b0, 4'b1111, 32'h0, 2, 32'h22334455));
      cq.push_back(ce(6'd14, 6'd20, 32'h22334455, 1'b1, 1'b0, 3));
      issue(mk(6'd20, 6'd14, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h500, 32'h0));
      fork
         wait_dmiss(n);
         begin
            @(posedge CLK); #1;
            FREEZE = 1'b1;
            repeat (3) @(posedge CLK);
            #1 FREEZE = 1'b0;
         end
      join
      check("dmiss_cycles_freeze", n, 5);

      // Issue while frozen in IDLE is dropped.
      @(posedge CLK); #1;
      FREEZE = 1'b1;
      issue(mk(6'd21, 6'd15, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h600, 32'h0));
      check("freeze_blocks_issue", {31'd0, DMISS}, 32'd0);
      FREEZE = 1'b0;
      repeat (2) @(posedge CLK);
      #1 check("freeze_blocks_issue_later", {31'd0, DMISS}, 32'd0);

      // Issue during a commit flush is dropped.
      flush_fCOM = 1'b1;
      issue(mk(6'd22, 6'd16, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h700, 32'h0));
      check("flush_blocks_issue", {31'd0, DMISS}, 32'd0);
      flush_fCOM = 1'b0;

      repeat (5) @(posedge CLK);
      #1;
      check("mem_queue_drained", mq.size(), 32'd0);
      check("cdb_queue_drained", cq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
